// File: rtl/rv_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : rv_mul_pipe
//  Purpose  : Pipelined RISC-V M-extension multiplier
//             (MUL/MULH/MULHSU/MULHU, plus MULW on RV64).
//             The pipe has STAGES slots, and each slot is a valid bit plus a
//             payload. When the output is stalled, the whole pipe stalls.
//             A flush kills every in-flight request.
//  Ports    : clk, rst                 clock, asynchronous active-high reset
//             mul_valid_i/mul_ready_o  request handshake
//             mul_op_i, mul_word_i     operation select, W-variant
//             mul_op1_i, mul_op2_i     rs1 / rs2 operands
//             mul_flush_i              discard all in-flight requests
//             mul_valid_o/mul_ready_i  result handshake
//             mul_result_o             result (don't-care while !mul_valid_o)
//  Revision : 1.0  initial release
// ============================================================================
module rv_mul_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_valid_i,
    output logic            mul_ready_o,
    input  logic [1:0]      mul_op_i,
    input  logic            mul_word_i,
    input  logic [XLEN-1:0] mul_op1_i,
    input  logic [XLEN-1:0] mul_op2_i,
    input  logic            mul_flush_i,
    output logic            mul_valid_o,
    input  logic            mul_ready_i,
    output logic [XLEN-1:0] mul_result_o
);

    localparam int c_EW = XLEN + 1;   // extended operand width
    localparam int c_PW = 2 * XLEN;   // full product width

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("rv_mul_pipe: XLEN must be 32 or 64");
        end
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("rv_mul_pipe: STAGES must be in 1..4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake and valid-bit shift register
    // ------------------------------------------------------------------
    logic [STAGES-1:0] r_vld;
    logic              w_adv;
    logic              w_acc;

    assign mul_valid_o = r_vld[STAGES-1];
    assign mul_ready_o = !mul_valid_o || mul_ready_i;
    assign w_adv       = mul_ready_o;
    assign w_acc       = mul_valid_i && mul_ready_o && !mul_flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else if (mul_flush_i) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld[0] <= w_acc;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand extension (before the first slot)
    // ------------------------------------------------------------------
    logic            w_word;
    logic            w_hi;
    logic            w_s1;
    logic            w_s2;
    logic [c_EW-1:0] w_a;
    logic [c_EW-1:0] w_b;

    always_comb begin
        w_word = mul_word_i && (XLEN == 64);
        w_s1   = (mul_op_i != 2'b11);   // MUL, MULH, MULHSU sign rs1
        w_s2   = !mul_op_i[1];          // MUL, MULH sign rs2
        w_hi   = (mul_op_i != 2'b00) && !w_word;
        if (w_word) begin
            // Only product bits [31:0] are kept, so sign-extending the low
            // words is as good as any other extension.
            w_a = c_EW'($signed(mul_op1_i[31:0]));
            w_b = c_EW'($signed(mul_op2_i[31:0]));
        end else begin
            w_a = {w_s1 & mul_op1_i[XLEN-1], mul_op1_i};
            w_b = {w_s2 & mul_op2_i[XLEN-1], mul_op2_i};
        end
    end

    // First slot payload: the extended operands and the result-select flags
    logic [c_EW-1:0] r_a;
    logic [c_EW-1:0] r_b;
    logic            r_hi;
    logic            r_word;

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_a    <= w_a;
            r_b    <= w_b;
            r_hi   <= w_hi;
            r_word <= w_word;
        end
    end

    // ------------------------------------------------------------------
    // Multiply. The operands are sign-extended to the product width, so an
    // unsigned multiply modulo 2^(2*XLEN) gives the correct two's-complement
    // product.
    // ------------------------------------------------------------------
    logic [c_PW-1:0] w_ax;
    logic [c_PW-1:0] w_bx;
    logic [c_PW-1:0] w_prod;
    logic [XLEN-1:0] w_res0;

    assign w_ax   = {{(XLEN-1){r_a[XLEN]}}, r_a};
    assign w_bx   = {{(XLEN-1){r_b[XLEN]}}, r_b};
    assign w_prod = w_ax * w_bx;

    always_comb begin
        if (r_word) begin
            w_res0 = XLEN'($signed(w_prod[31:0]));
        end else if (r_hi) begin
            w_res0 = w_prod[c_PW-1:XLEN];
        end else begin
            w_res0 = w_prod[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Remaining slots carry the selected result
    // ------------------------------------------------------------------
    generate
        if (STAGES == 1) begin : g_single
            assign mul_result_o = w_res0;
        end else begin : g_multi
            logic [XLEN-1:0] r_res [1:STAGES-1];

            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_res[1] <= w_res0;
                    for (int i = 2; i < STAGES; i++) begin
                        r_res[i] <= r_res[i-1];
                    end
                end
            end

            assign mul_result_o = r_res[STAGES-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/rv_mul_pipe.md
RV_MUL_PIPE -- requirements
Module: rv_mul_pipe

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; legal values 32 and 64 only.
REQ-002 Parameter STAGES, default 2, pipeline depth in cycles; legal range 1..4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mul_valid_i  input  1  request valid.
REQ-006 mul_ready_o  output  1  block can accept a request this cycle.
REQ-007 mul_op_i  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-008 mul_word_i  input  1  RV64 W-variant (MULW); ignored when XLEN=32.
REQ-009 mul_op1_i  input  XLEN  rs1 operand.
REQ-010 mul_op2_i  input  XLEN  rs2 operand.
REQ-011 mul_flush_i  input  1  kill all in-flight requests.
REQ-012 mul_valid_o  output  1  result valid.
REQ-013 mul_ready_i  input  1  consumer accepts result.
REQ-014 mul_result_o  output  XLEN  result.

Function
REQ-015 Request accepted on a rising edge where mul_valid_i && mul_ready_o && !mul_flush_i.
REQ-016 Result delivered on a rising edge where mul_valid_o && mul_ready_i.
REQ-017 Pipeline holds STAGES slots, each a valid bit plus payload; the last slot drives mul_valid_o/mul_result_o.
REQ-018 Stall: mul_ready_o = !mul_valid_o || mul_ready_i; when low, every slot holds its contents (whole-pipe stall, no bubble collapse).
REQ-019 Latency: with no stall, a request accepted at edge N yields mul_valid_o high after edge N+STAGES-1... precisely, visible in the cycle after edge N+STAGES-1 (STAGES=1: visible in the cycle after acceptance).
REQ-020 Throughput: one request per cycle sustained while mul_ready_i is high; results in acceptance order.
REQ-021 Operand extension to XLEN+1 bits: MUL/MULH sign op1 and op2; MULHSU sign op1, zero op2; MULHU zero both.
REQ-022 Full product 2*XLEN bits; MUL returns bits [XLEN-1:0]; MULH/MULHSU/MULHU return bits [2*XLEN-1:XLEN].
REQ-023 mul_word_i=1 (XLEN=64): use low 32 bits of each operand, op field ignored, result = sign-extension of bits [31:0] of the 32x32 product.
REQ-024 Sign handling and extension complete in the first stage; the multiply may be split across stages but every product bit is defined at the last slot.
REQ-025 Flush: on an edge where mul_flush_i=1, all valid bits clear, mul_valid_i that cycle is dropped; mul_valid_o low the following cycle; flush overrides a simultaneous accept and deliver.
REQ-026 mul_result_o is don't-care when mul_valid_o=0; payload registers need not be reset.
REQ-027 No combinational path from mul_valid_i or operands to any output; mul_ready_i to mul_ready_o is the only combinational path.

Reset
REQ-028 rst=1 asynchronously clears all valid bits: mul_valid_o=0, mul_ready_o=1 immediately.
REQ-029 Reset mid-operation discards all in-flight requests; no result is produced for them after rst deasserts.
REQ-030 First request accepted on the first rising edge after rst deasserts.

Verification
REQ-031 XLEN=64, MUL, op1=11424, op2=-22338 -> 0xFFFFFFFFF0CA1EC0; MULH same operands -> 0xFFFFFFFFFFFFFFFF.
REQ-032 XLEN=64, MULH 0x8000000000000000 x 0x8000000000000000 -> 0x4000000000000000; MULHU 0xFFFF..FF x 0xFFFF..FF -> 0xFFFFFFFFFFFFFFFE; MULHSU -1 x 2 -> 0xFFFFFFFFFFFFFFFF.
REQ-033 MULW 0x7FFFFFFF x 2 -> 0xFFFFFFFFFFFFFFFE; XLEN=32 MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
REQ-034 STAGES=1..4, back-to-back 16 requests, mul_ready_i=1 -> results in order, first at latency STAGES, one per cycle.
REQ-035 mul_ready_i held low 5 cycles with pipe full -> mul_ready_o=0, outputs stable, no loss or duplication after release.
REQ-036 Flush or rst asserted with 2 requests in flight -> mul_valid_o=0 next cycle, no stale result ever appears.
